// File: rtl/lsu_pkg.sv
// Purpose: shared types and helpers for the load/store unit.
//   - RV32I func3 encodings (F3_B..F3_HU)
//   - lsu_state_t: FSM encoding (IDLE, BEAT0, BEAT1)
//   - is_crossing / func3_legal / size_mask: request decode helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } lsu_state_t;

    // Access spills into the next word
    function automatic logic is_crossing(input logic [2:0] func3, input logic [1:0] off);
        logic r;
        case (func3)
            F3_H, F3_HU: r = (off == 2'd3);
            F3_W:        r = (off != 2'd0);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Unsigned widths are load-only
    function automatic logic func3_legal(input logic [2:0] func3, input logic is_store);
        logic r;
        case (func3)
            F3_B, F3_H, F3_W: r = 1'b1;
            F3_BU, F3_HU:     r = !is_store;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    // Unshifted byte-enable pattern for the access size
    function automatic logic [3:0] size_mask(input logic [2:0] func3);
        logic [3:0] r;
        case (func3[1:0])
            2'b00:   r = 4'b0001;
            2'b01:   r = 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Purpose: combinational lane logic for the load/store unit.
//   i_func3, i_off     : access width and byte offset
//   i_store_data       : LSB-aligned store data
//   i_load_buf         : 64-bit assembly buffer (beat0 word low, beat1 word high)
//   o_be0 / o_be1      : byte enables for beat 0 / beat 1
//   o_wdata0 / o_wdata1: lane-shifted store data for beat 0 / beat 1
//   o_load_data        : extracted and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_store_data,
    input  logic [63:0] i_load_buf,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    output logic [31:0] o_load_data
);

    logic [63:0] w_wdata_wide;
    logic [7:0]  w_be_wide;
    logic [31:0] w_raw;

    // Shift across a two-word window; the upper half feeds beat 1
    assign w_wdata_wide = {32'h0, i_store_data} << {i_off, 3'b000};
    assign w_be_wide    = {4'h0, size_mask(i_func3)} << i_off;

    assign o_wdata0 = w_wdata_wide[31:0];
    assign o_wdata1 = w_wdata_wide[63:32];
    assign o_be0    = w_be_wide[3:0];
    assign o_be1    = w_be_wide[7:4];

    assign w_raw = 32'(i_load_buf >> {i_off, 3'b000});

    always_comb begin
        o_load_data = w_raw;
        case (i_func3)
            F3_B:    o_load_data = {{24{w_raw[7]}}, w_raw[7:0]};
            F3_H:    o_load_data = {{16{w_raw[15]}}, w_raw[15:0]};
            F3_BU:   o_load_data = {24'h0, w_raw[7:0]};
            F3_HU:   o_load_data = {16'h0, w_raw[15:0]};
            default: o_load_data = w_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: memory-stage load/store front end. Converts RV32I byte-addressed
// loads/stores into word beats with byte enables, splits word-crossing
// accesses into two beats, and returns a registered load result or fault.
//   clock, reset (sync, active-high)
//   req*  : request from EX/MEM, reqReady stalls upstream
//   mem*  : word-organised data memory port (combinational read data)
//   resp* : one-cycle response pulse to MEM/WB
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqLoad,
    input  logic              reqStore,
    input  logic [2:0]        reqFunc3,
    input  logic [31:0]       reqAddr,
    input  logic [31:0]       reqStoreData,
    input  logic [4:0]        reqRd,
    output logic [ADDR_W-1:0] memWordAddr,
    output logic              memReadEnable,
    output logic              memWriteEnable,
    output logic [3:0]        memByteEnable,
    output logic [31:0]       memWriteData,
    input  logic [31:0]       memReadData,
    output logic              respValid,
    output logic              respFault,
    output logic [31:0]       respData,
    output logic [4:0]        respRd
);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_word;
    logic [1:0]        r_off;
    logic [2:0]        r_func3;
    logic              r_load;
    logic              r_store;
    logic              r_fault;
    logic              r_cross;
    logic [31:0]       r_store_data;
    logic [4:0]        r_rd;
    logic [31:0]       r_buf_lo;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [31:0]       r_resp_data;
    logic [4:0]        r_resp_rd;

    logic              w_ready;
    logic              w_accept;
    logic              w_req_fault;
    logic              w_beat_active;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wdata0;
    logic [31:0]       w_wdata1;
    logic [31:0]       w_beat0_lanes;
    logic [63:0]       w_load_buf;
    logic [31:0]       w_load_data;
    logic              w_unused;

    assign w_unused = ^reqAddr[31:ADDR_W+2];

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_BEAT1) ||
                      ((r_state == S_BEAT0) && !r_cross);
    assign w_accept = reqValid && w_ready && (reqLoad || reqStore);
    assign w_req_fault = (reqLoad && reqStore) || !func3_legal(reqFunc3, reqStore);

    assign reqReady = w_ready;

    // Faulted requests hold the FSM for one cycle but never touch memory
    assign w_beat_active = !reset && !r_fault &&
                           ((r_state == S_BEAT0) || (r_state == S_BEAT1));

    assign memReadEnable  = w_beat_active && r_load;
    assign memWriteEnable = w_beat_active && r_store;
    assign memWordAddr    = (r_state == S_BEAT1) ? r_word + ADDR_W'(1) : r_word;
    assign memByteEnable  = !w_beat_active ? 4'h0 :
                            (r_state == S_BEAT1) ? w_be1 : w_be0;
    assign memWriteData   = (r_state == S_BEAT1) ? w_wdata1 : w_wdata0;

    // Only lanes at or above the offset belong to this access
    always_comb begin
        w_beat0_lanes = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) >= r_off) begin
                w_beat0_lanes[8*i +: 8] = memReadData[8*i +: 8];
            end
        end
    end

    assign w_load_buf = (r_state == S_BEAT1) ? {memReadData, r_buf_lo}
                                             : {32'h0, w_beat0_lanes};

    lsu_align u_align (
        .i_func3      (r_func3),
        .i_off        (r_off),
        .i_store_data (r_store_data),
        .i_load_buf   (w_load_buf),
        .o_be0        (w_be0),
        .o_be1        (w_be1),
        .o_wdata0     (w_wdata0),
        .o_wdata1     (w_wdata1),
        .o_load_data  (w_load_data)
    );

    // FSM, request capture and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_rd    <= 5'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_BEAT0;
                end
                S_BEAT0: begin
                    if (r_fault) begin
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b1;
                        r_resp_data  <= 32'h0;
                        r_resp_rd    <= r_rd;
                        r_state      <= w_accept ? S_BEAT0 : S_IDLE;
                    end else if (r_cross) begin
                        r_buf_lo <= w_beat0_lanes;
                        r_state  <= S_BEAT1;
                    end else begin
                        if (r_load) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_load_data;
                            r_resp_rd    <= r_rd;
                        end
                        r_state <= w_accept ? S_BEAT0 : S_IDLE;
                    end
                end
                S_BEAT1: begin
                    if (r_load) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_load_data;
                        r_resp_rd    <= r_rd;
                    end
                    r_state <= w_accept ? S_BEAT0 : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                r_word       <= reqAddr[ADDR_W+1:2];
                r_off        <= reqAddr[1:0];
                r_func3      <= reqFunc3;
                r_load       <= reqLoad;
                r_store      <= reqStore;
                r_fault      <= w_req_fault;
                r_cross      <= is_crossing(reqFunc3, reqAddr[1:0]) && !w_req_fault;
                r_store_data <= reqStoreData;
                r_rd         <= reqRd;
            end
        end
    end

    assign respValid = r_resp_valid;
    assign respFault = r_resp_fault;
    assign respData  = r_resp_data;
    assign respRd    = r_resp_rd;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: self-checking bench for load_store_unit with a behavioural word
// memory and a response scoreboard (expected data, rd, fault, cycle).
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              reqValid;
    logic              reqReady;
    logic              reqLoad;
    logic              reqStore;
    logic [2:0]        reqFunc3;
    logic [31:0]       reqAddr;
    logic [31:0]       reqStoreData;
    logic [4:0]        reqRd;
    logic [ADDR_W-1:0] memWordAddr;
    logic              memReadEnable;
    logic              memWriteEnable;
    logic [3:0]        memByteEnable;
    logic [31:0]       memWriteData;
    logic [31:0]       memReadData;
    logic              respValid;
    logic              respFault;
    logic [31:0]       respData;
    logic [4:0]        respRd;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqLoad        (reqLoad),
        .reqStore       (reqStore),
        .reqFunc3       (reqFunc3),
        .reqAddr        (reqAddr),
        .reqStoreData   (reqStoreData),
        .reqRd          (reqRd),
        .memWordAddr    (memWordAddr),
        .memReadEnable  (memReadEnable),
        .memWriteEnable (memWriteEnable),
        .memByteEnable  (memByteEnable),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData),
        .respValid      (respValid),
        .respFault      (respFault),
        .respData       (respData),
        .respRd         (respRd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural data memory
    logic [31:0] mem [0:DEPTH-1];
    assign memReadData = mem[memWordAddr];
    always @(posedge clock) begin
        if (memWriteEnable) begin
            for (int i = 0; i < 4; i++) begin
                if (memByteEnable[i]) mem[memWordAddr][8*i +: 8] <= memWriteData[8*i +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Response monitor: every respValid must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && respValid) begin
            check_eq("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("resp_data",  respData,         e.data);
                check_eq("resp_rd",    32'(respRd),      32'(e.rd));
                check_eq("resp_fault", 32'(respFault),   32'(e.fault));
                check_eq("resp_cycle", 32'(cyc),         32'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive one request, wait for acceptance, queue the expected response
    task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic exp_fault,
                        input logic [31:0] exp_data, input int lat,
                        output int acc_cyc);
        logic rdy;
        int   n;
        exp_t e;
        reqValid     = 1'b1;
        reqLoad      = ld;
        reqStore     = st;
        reqFunc3     = f3;
        reqAddr      = addr;
        reqStoreData = data;
        reqRd        = rd;
        n   = 0;
        rdy = 1'b0;
        do begin
            @(negedge clock);
            rdy = reqReady;
            @(posedge clock);
            n++;
        end while (!rdy && n < 20);
        #1;
        reqValid = 1'b0;
        acc_cyc  = cyc;
        check_eq("accepted", 32'(rdy), 32'd1);
        if (rdy && (ld || exp_fault)) begin
            e.data  = exp_data;
            e.rd    = rd;
            e.fault = exp_fault;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int ac;
        int prev;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
        reset = 1'b1; reqValid = 1'b0; reqLoad = 1'b0; reqStore = 1'b0;
        reqFunc3 = 3'b000; reqAddr = 32'h0; reqStoreData = 32'h0; reqRd = 5'd0;
        idle(3);
        check_eq("rst_resp_valid", 32'(respValid), 32'd0);
        check_eq("rst_resp_fault", 32'(respFault), 32'd0);
        check_eq("rst_resp_data",  respData,       32'd0);
        check_eq("rst_resp_rd",    32'(respRd),    32'd0);
        check_eq("rst_mem_en",     32'({memReadEnable, memWriteEnable}), 32'd0);
        reset = 1'b0;
        idle(1);
        check_eq("idle_ready", 32'(reqReady), 32'd1);

        // Aligned SW then LW
        send(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 1, ac);
        check_eq("sw_we",    32'(memWriteEnable), 32'd1);
        check_eq("sw_word",  32'(memWordAddr),    32'd4);
        check_eq("sw_be",    32'(memByteEnable),  32'hF);
        check_eq("sw_wdata", memWriteData,        32'hDEADBEEF);
        send(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b0, 32'hDEADBEEF, 1, ac);
        check_eq("lw_re",   32'(memReadEnable), 32'd1);
        check_eq("lw_word", 32'(memWordAddr),   32'd4);
        check_eq("lw_be",   32'(memByteEnable), 32'hF);
        idle(3);

        // Byte/half sign and zero extension
        mem[1] <= 32'h80FF7F80;
        send(1'b1, 1'b0, 3'b000, 32'h4, 32'h0, 5'd1, 1'b0, 32'hFFFFFF80, 1, ac);
        send(1'b1, 1'b0, 3'b100, 32'h4, 32'h0, 5'd2, 1'b0, 32'h00000080, 1, ac);
        send(1'b1, 1'b0, 3'b000, 32'h5, 32'h0, 5'd3, 1'b0, 32'h0000007F, 1, ac);
        send(1'b1, 1'b0, 3'b001, 32'h6, 32'h0, 5'd4, 1'b0, 32'hFFFF80FF, 1, ac);
        send(1'b1, 1'b0, 3'b101, 32'h4, 32'h0, 5'd6, 1'b0, 32'h00007F80, 1, ac);
        idle(3);

        // Crossing LW at offset 3
        mem[1] <= 32'h44332211;
        mem[2] <= 32'h88776655;
        send(1'b1, 1'b0, 3'b010, 32'h7, 32'h0, 5'd7, 1'b0, 32'h77665544, 2, ac);
        check_eq("xlw_b0_word",  32'(memWordAddr),   32'd1);
        check_eq("xlw_b0_re",    32'(memReadEnable), 32'd1);
        check_eq("xlw_b0_ready", 32'(reqReady),      32'd0);
        idle(1);
        check_eq("xlw_b1_word",  32'(memWordAddr),   32'd2);
        check_eq("xlw_b1_ready", 32'(reqReady),      32'd1);
        idle(3);

        // Crossing SH at offset 3
        mem[0] <= 32'h0;
        mem[1] <= 32'h0;
        send(1'b0, 1'b1, 3'b001, 32'h3, 32'h0000ABCD, 5'd0, 1'b0, 32'h0, 1, ac);
        check_eq("xsh_b0_word", 32'(memWordAddr),         32'd0);
        check_eq("xsh_b0_be",   32'(memByteEnable),       32'b1000);
        check_eq("xsh_b0_lane", 32'(memWriteData[31:24]), 32'hCD);
        idle(1);
        check_eq("xsh_b1_word", 32'(memWordAddr),         32'd1);
        check_eq("xsh_b1_be",   32'(memByteEnable),       32'b0001);
        check_eq("xsh_b1_lane", 32'(memWriteData[7:0]),   32'hAB);
        idle(1);
        check_eq("xsh_mem0", mem[0], 32'hCD000000);
        check_eq("xsh_mem1", mem[1], 32'h000000AB);
        idle(1);

        // Top-word wrap
        mem[DEPTH-1] <= 32'hDDCCBBAA;
        mem[0]       <= 32'h44332211;
        send(1'b1, 1'b0, 3'b010, 32'(DEPTH * 4 - 2), 32'h0, 5'd9, 1'b0, 32'h2211DDCC, 2, ac);
        check_eq("wrap_b0_word", 32'(memWordAddr), 32'(DEPTH - 1));
        idle(1);
        check_eq("wrap_b1_word", 32'(memWordAddr), 32'd0);
        idle(3);

        // Faults: illegal load func3, unsigned store, load+store
        send(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 5'd10, 1'b1, 32'h0, 1, ac);
        check_eq("flt_ld_en", 32'({memReadEnable, memWriteEnable}), 32'd0);
        send(1'b0, 1'b1, 3'b100, 32'h24, 32'h12345678, 5'd11, 1'b1, 32'h0, 1, ac);
        check_eq("flt_st_en", 32'({memReadEnable, memWriteEnable}), 32'd0);
        send(1'b1, 1'b1, 3'b010, 32'h28, 32'h12345678, 5'd12, 1'b1, 32'h0, 1, ac);
        check_eq("flt_ls_en", 32'({memReadEnable, memWriteEnable}), 32'd0);
        idle(1);
        check_eq("flt_mem9", mem[9], 32'h0);
        idle(2);

        // Neither load nor store: never accepted
        reqValid = 1'b1; reqLoad = 1'b0; reqStore = 1'b0; reqFunc3 = 3'b010; reqAddr = 32'h30;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_eq("nop_ready", 32'(reqReady), 32'd1);
            check_eq("nop_en",    32'({memReadEnable, memWriteEnable}), 32'd0);
        end
        reqValid = 1'b0;
        idle(2);

        // Reset during BEAT1 of a crossing SW
        mem[2] <= 32'h0;
        mem[3] <= 32'hA5A5A5A5;
        send(1'b0, 1'b1, 3'b010, 32'h9, 32'h11223344, 5'd0, 1'b0, 32'h0, 1, ac);
        check_eq("rsw_b0_word", 32'(memWordAddr),   32'd2);
        check_eq("rsw_b0_be",   32'(memByteEnable), 32'b1110);
        idle(1);
        check_eq("rsw_b1_word", 32'(memWordAddr),    32'd3);
        check_eq("rsw_b1_we",   32'(memWriteEnable), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rsw_rst_we",  32'(memWriteEnable), 32'd0);
        idle(1);
        reset = 1'b0;
        #1;
        check_eq("rsw_ready",   32'(reqReady),       32'd1);
        check_eq("rsw_valid",   32'(respValid),      32'd0);
        check_eq("rsw_we_idle", 32'(memWriteEnable), 32'd0);
        check_eq("rsw_mem2",    mem[2],              32'h22334400);
        check_eq("rsw_mem3",    mem[3],              32'hA5A5A5A5);
        idle(1);

        // Back-to-back aligned LWs
        for (int k = 0; k < 4; k++) mem[20 + k] <= 32'hC0DE0000 + 32'(k);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 1'b0, 3'b010, 32'(80 + 4 * k), 32'h0, 5'(20 + k), 1'b0,
                 32'hC0DE0000 + 32'(k), 1, ac);
            if (k > 0) check_eq("b2b_gap", 32'(ac - prev), 32'd1);
            prev = ac;
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(2);
        check_eq("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
